// File: rtl/adsr_envelope.sv
// adsr_envelope: ADSR gain generator that scales the oscillator sample stream
module adsr_envelope #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ACC_BITS     = 24,
    parameter int GAIN_BITS    = 16
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           gate_in,
    input  logic                           tick_in,
    input  logic        [ACC_BITS-1:0]     attack_rate_in,
    input  logic        [ACC_BITS-1:0]     decay_rate_in,
    input  logic        [GAIN_BITS-1:0]    sustain_level_in,
    input  logic        [ACC_BITS-1:0]     release_rate_in,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    output logic signed [SAMPLE_WIDTH-1:0] val_out,
    output logic        [GAIN_BITS-1:0]    env_out,
    output logic                           busy_out
);
    localparam int PW = SAMPLE_WIDTH + GAIN_BITS + 1;
    localparam logic [ACC_BITS-1:0] MAX = '1;

    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

    state_t                    state_q, state_d;
    logic [ACC_BITS-1:0]       env_q, env_d;
    logic                      gate_q;
    logic signed [SAMPLE_WIDTH-1:0] s1_sample_q;
    logic [GAIN_BITS-1:0]      s1_g_q;
    logic signed [PW-1:0]      p_q;

    logic                rise;
    logic [ACC_BITS-1:0] s_lvl;
    logic [ACC_BITS:0]   att_sum, dec_lim;
    logic                att_top, dec_end, rel_end, held;

    assign rise    = gate_in & ~gate_q;
    assign s_lvl   = ACC_BITS'(sustain_level_in) << (ACC_BITS - GAIN_BITS);
    assign att_sum = {1'b0, env_q} + {1'b0, attack_rate_in};
    assign dec_lim = {1'b0, s_lvl} + {1'b0, decay_rate_in};
    assign att_top = att_sum >= {1'b0, MAX};
    assign dec_end = {1'b0, env_q} <= dec_lim;
    assign rel_end = env_q <= release_rate_in;
    assign held    = (state_q == ATTACK) || (state_q == DECAY) || (state_q == SUSTAIN);

    assign env_out  = env_q[ACC_BITS-1 -: GAIN_BITS];
    assign busy_out = state_q != IDLE;
    assign val_out  = SAMPLE_WIDTH'(p_q >>> GAIN_BITS);

    // Next state: retrigger beats gate release, which beats tick-driven arithmetic; env never wraps
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (rise) begin
            state_d = ATTACK;
        end else if (!gate_in && held) begin
            state_d = RELEASE;
        end else begin
            case (state_q)
                IDLE:    env_d = '0;
                SUSTAIN: env_d = s_lvl;
                ATTACK: if (tick_in) begin
                    env_d   = att_top ? MAX : att_sum[ACC_BITS-1:0];
                    state_d = att_top ? DECAY : ATTACK;
                end
                DECAY: if (tick_in) begin
                    env_d   = dec_end ? s_lvl : env_q - decay_rate_in;
                    state_d = dec_end ? SUSTAIN : DECAY;
                end
                RELEASE: if (tick_in) begin
                    env_d   = rel_end ? '0 : env_q - release_rate_in;
                    state_d = rel_end ? IDLE : RELEASE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Envelope state, accumulator and gate edge history
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            env_q   <= '0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            gate_q  <= gate_in;
        end
    end

    // Two-stage multiply: capture sample with current gain, then form the signed product
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_sample_q <= '0;
            s1_g_q      <= '0;
            p_q         <= '0;
        end else begin
            s1_sample_q <= sample_in;
            s1_g_q      <= env_out;
            p_q         <= PW'(s1_sample_q) * PW'($signed({1'b0, s1_g_q}));
        end
    end
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: vector table, directed sequences and a randomized reference model
module tb_adsr_envelope;
    logic clk_in = 1'b0, rst_in = 1'b1, gate_in = 1'b0, tick_in = 1'b0;
    logic [23:0] attack_rate_in = '0, decay_rate_in = '0, release_rate_in = '0;
    logic [15:0] sustain_level_in = '0;
    logic signed [15:0] sample_in = '0;
    logic signed [15:0] val_out;
    logic [15:0] env_out;
    logic busy_out;
    int n_cmp = 0, n_err = 0;

    typedef struct {
        bit g;
        bit t;
        logic [23:0] ar, dr, rr;
        logic [15:0] sus;
        logic [15:0] env;
        bit busy;
    } vec_t;
    vec_t tbl[17];

    longint m_env, s_full, gain;
    int m_ph;
    bit m_gate;
    longint hist[$];
    localparam longint MAXV = 64'hFFFFFF;

    adsr_envelope #(.SAMPLE_WIDTH(16), .ACC_BITS(24), .GAIN_BITS(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .gate_in(gate_in), .tick_in(tick_in),
        .attack_rate_in(attack_rate_in), .decay_rate_in(decay_rate_in),
        .sustain_level_in(sustain_level_in), .release_rate_in(release_rate_in),
        .sample_in(sample_in), .val_out(val_out), .env_out(env_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string n, input longint a, input longint e);
        n_cmp++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    initial begin
        tbl[0]  = '{1, 0, 24'h800000, 24'h0,      24'h0,      16'h0000, 16'h0000, 1};
        tbl[1]  = '{1, 1, 24'h000000, 24'h0,      24'h0,      16'h0000, 16'h0000, 1};
        tbl[2]  = '{1, 1, 24'h800000, 24'h0,      24'h0,      16'h0000, 16'h8000, 1};
        tbl[3]  = '{1, 1, 24'h800000, 24'h0,      24'h0,      16'h0000, 16'hFFFF, 1};
        tbl[4]  = '{1, 1, 24'h000000, 24'h0,      24'h0,      16'h0000, 16'hFFFF, 1};
        tbl[5]  = '{1, 1, 24'h000000, 24'hFFFFFF, 24'h0,      16'h0000, 16'h0000, 1};
        tbl[6]  = '{1, 1, 24'h000000, 24'h0,      24'h0,      16'h0000, 16'h0000, 1};
        tbl[7]  = '{0, 0, 24'h000000, 24'h0,      24'h0,      16'h0000, 16'h0000, 1};
        tbl[8]  = '{0, 1, 24'h000000, 24'h0,      24'h123,    16'h0000, 16'h0000, 0};
        tbl[9]  = '{0, 1, 24'h000000, 24'h0,      24'h123,    16'h0000, 16'h0000, 0};
        tbl[10] = '{1, 0, 24'h000000, 24'h0,      24'h0,      16'h0000, 16'h0000, 1};
        tbl[11] = '{1, 1, 24'hFFFFF0, 24'h0,      24'h0,      16'h0000, 16'hFFFF, 1};
        tbl[12] = '{1, 1, 24'h000010, 24'h0,      24'h0,      16'h0000, 16'hFFFF, 1};
        tbl[13] = '{1, 1, 24'h000000, 24'hFF,     24'h0,      16'hFFFF, 16'hFFFF, 1};
        tbl[14] = '{1, 0, 24'h000000, 24'h0,      24'h0,      16'h1234, 16'h1234, 1};
        tbl[15] = '{0, 0, 24'h000000, 24'h0,      24'h0,      16'h1234, 16'h1234, 1};
        tbl[16] = '{0, 1, 24'h000000, 24'h0,      24'h200000, 16'h1234, 16'h0000, 0};

        step();
        chk("rst_env", env_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_val", val_out, 0);
        rst_in = 0;

        gate_in = 1; attack_rate_in = 24'h100000; tick_in = 1;
        step();
        repeat (7) step();
        chk("pre_async_env", env_out, 16'h7000);
        #3 rst_in = 1;
        #1;
        chk("async_env", env_out, 0);
        chk("async_busy", busy_out, 0);
        chk("async_val", val_out, 0);
        gate_in = 0; tick_in = 0;
        step();
        rst_in = 0;

        for (int i = 0; i < 17; i++) begin
            gate_in = tbl[i].g; tick_in = tbl[i].t;
            attack_rate_in = tbl[i].ar; decay_rate_in = tbl[i].dr;
            release_rate_in = tbl[i].rr; sustain_level_in = tbl[i].sus;
            step();
            chk($sformatf("tbl%0d_env", i), env_out, tbl[i].env);
            chk($sformatf("tbl%0d_busy", i), busy_out, tbl[i].busy);
        end

        gate_in = 1; tick_in = 1; attack_rate_in = 24'h100000;
        decay_rate_in = 24'h080000; sustain_level_in = 16'h8000;
        step();
        repeat (15) step();
        chk("att15_env", env_out, 16'hF000);
        step();
        chk("att16_env", env_out, 16'hFFFF);
        chk("att16_busy", busy_out, 1);
        repeat (15) step();
        chk("dec15_env", env_out, 16'h87FF);
        step();
        chk("dec16_env", env_out, 16'h8000);
        sustain_level_in = 16'h4000; tick_in = 0;
        step();
        chk("sus_track", env_out, 16'h4000);

        gate_in = 0; release_rate_in = 24'h100000;
        step();
        chk("rel_enter_env", env_out, 16'h4000);
        chk("rel_enter_busy", busy_out, 1);
        sustain_level_in = 16'h2000;
        step();
        chk("rel_hold", env_out, 16'h4000);
        tick_in = 1;
        repeat (3) step();
        chk("rel3_env", env_out, 16'h1000);
        step();
        chk("rel4_env", env_out, 0);
        chk("rel4_busy", busy_out, 0);

        gate_in = 1; tick_in = 0;
        step();
        attack_rate_in = 24'h400000; tick_in = 1;
        step();
        gate_in = 0; tick_in = 0;
        step();
        release_rate_in = 24'h200000; tick_in = 1;
        step();
        chk("retrig_pre", env_out, 16'h2000);
        gate_in = 1;
        step();
        chk("retrig_env", env_out, 16'h2000);
        chk("retrig_busy", busy_out, 1);
        tick_in = 0;
        step();
        chk("retrig_hold", env_out, 16'h2000);
        tick_in = 1;
        step();
        chk("retrig_att", env_out, 16'h6000);

        attack_rate_in = 24'hFFFFFF;
        step();
        tick_in = 0; sample_in = 1000;
        step();
        sample_in = -32768;
        step();
        chk("scale_pos", val_out, 999);
        step();
        chk("scale_neg", val_out, -32768);
        chk("scale_env", env_out, 16'hFFFF);
        gate_in = 0; release_rate_in = 24'hFFFFFF; tick_in = 1; sample_in = 1000;
        step();
        step();
        tick_in = 0;
        repeat (3) step();
        chk("scale_zero", val_out, 0);
        chk("scale_idle", busy_out, 0);

        rst_in = 1;
        step();
        rst_in = 0;
        m_env = 0; m_ph = 0; m_gate = 0;
        hist.delete();
        hist.push_back(0);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) gate_in = ~gate_in;
            tick_in = ($urandom_range(0, 2) == 0);
            attack_rate_in  = ($urandom_range(0, 7) == 0) ? 24'h0 : 24'($urandom_range(0, 24'h3FFFFF));
            decay_rate_in   = ($urandom_range(0, 7) == 0) ? 24'h0 : 24'($urandom_range(0, 24'h3FFFFF));
            release_rate_in = ($urandom_range(0, 7) == 0) ? 24'h0 : 24'($urandom_range(0, 24'h3FFFFF));
            if ($urandom_range(0, 49) == 0) sustain_level_in = 16'($urandom);
            sample_in = 16'($urandom);
            gain = m_env >> 8;
            hist.push_back((longint'(sample_in) * gain) >>> 16);
            s_full = longint'(sustain_level_in) << 8;
            if (gate_in && !m_gate) m_ph = 1;
            else if (!gate_in && m_ph >= 1 && m_ph <= 3) m_ph = 4;
            else if (m_ph == 0) m_env = 0;
            else if (m_ph == 3) m_env = s_full;
            else if (tick_in) begin
                if (m_ph == 1) begin
                    if (m_env + longint'(attack_rate_in) >= MAXV) begin m_env = MAXV; m_ph = 2; end
                    else m_env = m_env + longint'(attack_rate_in);
                end else if (m_ph == 2) begin
                    if (m_env <= s_full + longint'(decay_rate_in)) begin m_env = s_full; m_ph = 3; end
                    else m_env = m_env - longint'(decay_rate_in);
                end else begin
                    if (m_env <= longint'(release_rate_in)) begin m_env = 0; m_ph = 0; end
                    else m_env = m_env - longint'(release_rate_in);
                end
            end
            m_gate = gate_in;
            step();
            chk("rnd_env", env_out, m_env >> 8);
            chk("rnd_busy", busy_out, (m_ph != 0) ? 1 : 0);
            chk("rnd_val", val_out, hist.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
